// File: rtl/rat_int_controller.sv
// Four-source edge-captured, fixed-priority interrupt controller for the RAT MCU I/O bus.
// Optional WAIT_ACK re-delivery timeout is enabled by defining INTC_TIMEOUT_EN.
module rat_int_controller #(
    parameter int          N_SRC     = 4,
    parameter logic [7:0]  STATUS_ID = 8'h90,
    parameter logic [7:0]  MASK_ID   = 8'h91,
    parameter logic [7:0]  ACK_ID    = 8'h92,
    parameter int          PULSE_CYC = 2
`ifdef INTC_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic [7:0]       IN_DATA,
    output logic             IN_SEL,
    output logic             INTR
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_ACK
    } state_t;

    state_t           state_q;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mask_d;
    logic [1:0]       active_idx_q;
    logic [7:0]       pulse_cnt_q;
    logic             intr_q;
`ifdef INTC_TIMEOUT_EN
    logic [15:0]      timeout_cnt_q;
`endif

    logic             maskWr;
    logic             ackWr;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] ackClr;
    logic [N_SRC-1:0] req;
    logic             anyReq;
    logic [1:0]       firstIdx;
    logic [3:0]       pend4;
    logic [3:0]       mask4;
    logic             activeBitSet;
    logic             inService;
    logic             unused_out_port;

    assign maskWr = IO_STRB && (PORT_ID == MASK_ID);
    assign ackWr  = IO_STRB && (PORT_ID == ACK_ID);
    assign rise   = IRQ_IN & ~irq_prev_q;
    assign ackClr = ackWr ? OUT_PORT[N_SRC-1:0] : '0;

    // A new edge overrides an acknowledge of the same bit in the same cycle.
    assign pending_d = (pending_q & ~ackClr) | rise;
    assign mask_d    = maskWr ? OUT_PORT[N_SRC-1:0] : mask_q;

    assign pend4           = 4'(pending_q);
    assign mask4           = 4'(mask_q);
    assign activeBitSet    = pend4[active_idx_q];
    assign inService       = (state_q == ASSERT) || (state_q == WAIT_ACK);
    assign unused_out_port = ^OUT_PORT;

    always_comb begin
        req      = pending_q & mask_q;
        anyReq   = |req;
        firstIdx = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) firstIdx = 2'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            irq_prev_q    <= '0;
            pending_q     <= '0;
            mask_q        <= '0;
            active_idx_q  <= 2'd0;
            pulse_cnt_q   <= 8'd0;
            intr_q        <= 1'b0;
`ifdef INTC_TIMEOUT_EN
            timeout_cnt_q <= 16'd0;
`endif
        end else begin
            irq_prev_q <= IRQ_IN;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            case (state_q)
                IDLE: begin
                    intr_q <= 1'b0;
                    if (anyReq) begin
                        active_idx_q <= firstIdx;
                        pulse_cnt_q  <= 8'(PULSE_CYC);
                        intr_q       <= 1'b1;
                        state_q      <= ASSERT;
                    end
                end
                ASSERT: begin
                    // The pulse always completes, even if the source was acked meanwhile.
                    if (pulse_cnt_q <= 8'd1) begin
                        intr_q  <= 1'b0;
                        state_q <= WAIT_ACK;
`ifdef INTC_TIMEOUT_EN
                        timeout_cnt_q <= 16'd0;
`endif
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 8'd1;
                    end
                end
                WAIT_ACK: begin
                    intr_q <= 1'b0;
                    if (!activeBitSet) begin
                        state_q <= IDLE;
`ifdef INTC_TIMEOUT_EN
                    end else if (timeout_cnt_q == TIMEOUT_CYC - 16'd1) begin
                        pulse_cnt_q <= 8'(PULSE_CYC);
                        intr_q      <= 1'b1;
                        state_q     <= ASSERT;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 16'd1;
`endif
                    end
                end
                default: begin
                    intr_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        IN_DATA = 8'h00;
        IN_SEL  = 1'b0;
        if (PORT_ID == STATUS_ID) begin
            IN_DATA = {inService, 1'b0, active_idx_q, pend4};
            IN_SEL  = 1'b1;
        end else if (PORT_ID == MASK_ID) begin
            IN_DATA = {4'b0000, mask4};
            IN_SEL  = 1'b1;
        end
    end

    assign INTR = intr_q;

endmodule
